// File: rtl/tlc_sensor_conditioner.sv
// Farm-road sensor conditioner: synchronizes and debounces the raw vehicle
// sensor, turns accepted arrivals into a request for the traffic-light
// controller and handshakes with the farm-green phase.
module tlc_sensor_conditioner #(
    parameter int DEBOUNCE = 16,   // stable cycles needed to accept a level change (2..1023)
    parameter int HOLDOFF  = 8,    // quiet cycles after farm green ends (1..255)
    parameter int MAX_WAIT = 1000  // req_age threshold for req_overdue (1..65535)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sensor_raw,
    input  logic        farm_green,
    input  logic        count_clr,
    output logic        veh_req,
    output logic [7:0]  veh_count,
    output logic [15:0] req_age,
    output logic        req_overdue
);

    localparam logic [9:0]  DB_LAST   = 10'(DEBOUNCE - 1);
    localparam logic [7:0]  HOLD_LOAD = 8'(HOLDOFF - 1);
    localparam logic [15:0] WAIT_LIM  = 16'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    logic        sync1_q;
    logic        sync2_q;
    logic        s_filt_q;
    logic [9:0]  db_cnt_q;
    logic        arrive_q;
    state_t      state_q;
    state_t      state_d;
    logic [7:0]  hold_q;
    logic        pending_q;
    logic        veh_req_q;
    logic [7:0]  count_q;
    logic [15:0] age_q;
    logic        overdue_q;

    // Two-flop synchronizer for the asynchronous sensor; sync2_q is s_sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sensor_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count cycles s_sync disagrees with s_filt, flip on the DEBOUNCE-th
    // and emit a one-cycle arrival pulse only for a rising flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_filt_q <= 1'b0;
            db_cnt_q <= '0;
            arrive_q <= 1'b0;
        end else begin
            arrive_q <= 1'b0;
            if (sync2_q == s_filt_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                s_filt_q <= ~s_filt_q;
                db_cnt_q <= '0;
                arrive_q <= ~s_filt_q;
            end else begin
                db_cnt_q <= db_cnt_q + 10'd1;
            end
        end
    end

    // Next phase of the request handshake with the controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arrive_q) state_d = farm_green ? SERVE : REQ;
            REQ:     if (farm_green) state_d = SERVE;
            SERVE:   if (!farm_green) state_d = HOLD;
            HOLD: begin
                if (farm_green)          state_d = SERVE;
                else if (hold_q == 8'd0) state_d = (pending_q || s_filt_q) ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Phase register with registered request, holdoff timer, pending flag and request age.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            veh_req_q <= 1'b0;
            hold_q    <= '0;
            pending_q <= 1'b0;
            age_q     <= '0;
            overdue_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            veh_req_q <= (state_d == REQ);

            if (state_q == SERVE && state_d == HOLD)
                hold_q <= HOLD_LOAD;
            else if (state_q == HOLD && hold_q != 8'd0)
                hold_q <= hold_q - 8'd1;

            // An arrival seen while the farm road is being served (or just was)
            // must be re-requested once the holdoff expires.
            if (state_q == HOLD && state_d != HOLD)
                pending_q <= 1'b0;
            else if (arrive_q && (state_q == SERVE || state_q == HOLD))
                pending_q <= 1'b1;

            // Age counts cycles the request has been up, so it is 1 in the first REQ cycle.
            if (state_d == REQ)
                age_q <= (age_q == 16'hFFFF) ? age_q : age_q + 16'd1;
            else
                age_q <= '0;

            overdue_q <= (age_q >= WAIT_LIM);
        end
    end

    // Saturating arrival counter; clear wins over a coincident arrival.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (count_clr) begin
            count_q <= '0;
        end else if (arrive_q && count_q != 8'hFF) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign veh_req     = veh_req_q;
    assign veh_count   = count_q;
    assign req_age     = age_q;
    assign req_overdue = overdue_q;

endmodule

// File: tb/tb_tlc_sensor_conditioner.sv
// Bench for tlc_sensor_conditioner: directed scenarios with literal expectations
// plus a randomized phase, all outputs compared every cycle against a
// behavioural model of the conditioner.
module tb_tlc_sensor_conditioner;

    localparam int DEBOUNCE = 4;
    localparam int HOLDOFF  = 3;
    localparam int MAX_WAIT = 10;

    logic        clk;
    logic        rst_n;
    logic        sensor_raw;
    logic        farm_green;
    logic        count_clr;
    logic        veh_req;
    logic [7:0]  veh_count;
    logic [15:0] req_age;
    logic        req_overdue;

    int n_checks = 0;
    int n_errors = 0;

    tlc_sensor_conditioner #(
        .DEBOUNCE (DEBOUNCE),
        .HOLDOFF  (HOLDOFF),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sensor_raw  (sensor_raw),
        .farm_green  (farm_green),
        .count_clr   (count_clr),
        .veh_req     (veh_req),
        .veh_count   (veh_count),
        .req_age     (req_age),
        .req_overdue (req_overdue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_REQ, M_SERVE, M_HOLD} phase_t;

    bit     m_sync1, m_sync2, m_filt, m_arrive, m_pending, m_veh, m_over;
    int     m_run, m_hold, m_count, m_age;
    phase_t m_phase;
    bit     o_sync2, o_filt, o_arrive;
    int     o_age;
    phase_t nxt;

    task automatic model_reset();
        m_sync1 = 0; m_sync2 = 0; m_filt = 0; m_arrive = 0; m_pending = 0;
        m_veh = 0; m_over = 0; m_run = 0; m_hold = 0; m_count = 0; m_age = 0;
        m_phase = M_IDLE;
    endtask

    task automatic model_step();
        o_sync2 = m_sync2; o_filt = m_filt; o_arrive = m_arrive; o_age = m_age;
        // phase decision uses everything as it stood before the edge
        nxt = m_phase;
        case (m_phase)
            M_IDLE:  if (o_arrive) nxt = farm_green ? M_SERVE : M_REQ;
            M_REQ:   if (farm_green) nxt = M_SERVE;
            M_SERVE: if (!farm_green) nxt = M_HOLD;
            M_HOLD:  if (farm_green) nxt = M_SERVE;
                     else if (m_hold == 0) nxt = (m_pending || o_filt) ? M_REQ : M_IDLE;
            default: nxt = M_IDLE;
        endcase
        if (m_phase == M_HOLD && nxt != M_HOLD) m_pending = 0;
        else if (o_arrive && (m_phase == M_SERVE || m_phase == M_HOLD)) m_pending = 1;
        if (m_phase == M_SERVE && nxt == M_HOLD) m_hold = HOLDOFF - 1;
        else if (m_phase == M_HOLD && nxt == M_HOLD) m_hold = m_hold - 1;
        m_phase = nxt;
        // arrivals counted, clear first
        if (count_clr) m_count = 0;
        else if (o_arrive && m_count < 255) m_count = m_count + 1;
        // filtered level: run length of disagreement
        m_arrive = 0;
        if (o_sync2 == o_filt) m_run = 0;
        else if (m_run + 1 == DEBOUNCE) begin
            m_filt = ~o_filt; m_run = 0; m_arrive = m_filt;
        end else m_run = m_run + 1;
        m_sync2 = m_sync1;
        m_sync1 = sensor_raw;
        // request and its age as a run length of the request being up
        m_veh  = (m_phase == M_REQ);
        m_over = (o_age >= MAX_WAIT);
        m_age  = m_veh ? ((o_age < 65535) ? o_age + 1 : 65535) : 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            check("veh_req",     32'(veh_req),     32'(m_veh));
            check("veh_count",   32'(veh_count),   32'(m_count));
            check("req_age",     32'(req_age),     32'(m_age));
            check("req_overdue", 32'(req_overdue), 32'(m_over));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ----------------
    int sens_left;
    int fg_left;

    initial begin
        rst_n = 1'b0; sensor_raw = 1'b0; farm_green = 1'b0; count_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_veh_req",   32'(veh_req),     32'd0);
        check("reset_count",     32'(veh_count),   32'd0);
        check("reset_age",       32'(req_age),     32'd0);
        check("reset_overdue",   32'(req_overdue), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 3-cycle glitch is shorter than the debounce window
        sensor_raw = 1'b1;
        repeat (3) @(negedge clk);
        sensor_raw = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_veh_req", 32'(veh_req),   32'd0);
        check("glitch_count",   32'(veh_count), 32'd0);

        // held sensor: request after edge 7
        sensor_raw = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("lat_edge6_req", 32'(veh_req), 32'd0);
        @(posedge clk);
        #1 check("lat_edge7_req", 32'(veh_req), 32'd1);
        check("lat_count", 32'(veh_count), 32'd1);
        check("age_c1", 32'(req_age), 32'd1);
        check("ovd_c1", 32'(req_overdue), 32'd0);
        for (int k = 2; k <= 12; k++) begin
            @(posedge clk);
            #1 check("age_ck", 32'(req_age), 32'(k));
            check("ovd_ck", 32'(req_overdue), 32'(k >= 11));
        end

        // farm green serves the request
        @(negedge clk); farm_green = 1'b1;
        @(posedge clk);
        #1 check("serve_veh_req", 32'(veh_req), 32'd0);
        check("serve_age", 32'(req_age), 32'd0);
        @(posedge clk);
        #1 check("serve_overdue", 32'(req_overdue), 32'd0);
        @(negedge clk); sensor_raw = 1'b0;
        repeat (10) @(negedge clk);
        farm_green = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1 check("hold_idle_req", 32'(veh_req), 32'd0);
        end

        // arrival during SERVE is remembered through HOLD
        @(negedge clk); sensor_raw = 1'b1;
        repeat (8) @(negedge clk);
        farm_green = 1'b1;
        @(negedge clk); sensor_raw = 1'b0;
        repeat (10) @(negedge clk);
        sensor_raw = 1'b1;
        repeat (8) @(negedge clk);
        sensor_raw = 1'b0;
        repeat (10) @(negedge clk);
        farm_green = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1 check("pend_hold_req", 32'(veh_req), 32'd0);
        end
        @(posedge clk);
        #1 check("pend_rereq", 32'(veh_req), 32'd1);

        // randomized traffic, checked by the model every cycle
        sens_left = 0; fg_left = 0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if (sens_left == 0) begin
                sensor_raw = ~sensor_raw;
                sens_left  = $urandom_range(1, 9);
            end else sens_left--;
            if (fg_left == 0) begin
                farm_green = ~farm_green;
                fg_left    = $urandom_range(1, 25);
            end else fg_left--;
            count_clr = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        sensor_raw = 1'b0; farm_green = 1'b0; count_clr = 1'b0;
        repeat (20) @(negedge clk);

        // saturation of the arrival counter
        for (int a = 0; a < 260; a++) begin
            sensor_raw = 1'b1;
            repeat (8) @(negedge clk);
            sensor_raw = 1'b0;
            repeat (8) @(negedge clk);
        end
        #1 check("sat_count", 32'(veh_count), 32'd255);

        // clear coincident with an arrival wins
        @(negedge clk); sensor_raw = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk); count_clr = 1'b1;
        @(posedge clk);
        #1 check("clr_arrive_count", 32'(veh_count), 32'd0);
        @(negedge clk); count_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_req", 32'(veh_req), 32'd1);

        // asynchronous reset in the middle of REQ
        #2 rst_n = 1'b0;
        #1;
        check("arst_veh_req", 32'(veh_req),     32'd0);
        check("arst_count",   32'(veh_count),   32'd0);
        check("arst_age",     32'(req_age),     32'd0);
        check("arst_overdue", 32'(req_overdue), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("fresh_edge6_req", 32'(veh_req), 32'd0);
        @(posedge clk);
        #1 check("fresh_edge7_req", 32'(veh_req), 32'd1);
        check("fresh_count", 32'(veh_count), 32'd1);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
